pipe_latch_skid: RTL and testbench
==================================

Name: pipe_latch_skid

Overview:
- Parametrised inter-stage pipeline latch for the five-stage core. Successor to the fixed four-field 32-bit stage latches.
- Carries NFIELDS fields of WIDTH bits each, such as PC, A, B and IR.
- Adds a valid/ready handshake, a two-entry skid buffer for full-throughput back-pressure, a synchronous flush that injects a NOP bubble, and a saturating back-pressure cycle counter.
- Used between any pair of stages (F/D, D/X, X/M, M/W).

Parameters:
- WIDTH, 32: bits per field.
- NFIELDS, 4: number of fields; field k occupies bits [k*WIDTH +: WIDTH].
- IR_FIELD, 3: index of the instruction field that is overwritten on flush.
- NOP_IR, 32'h00000000: instruction word injected as the bubble; width WIDTH.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream stage presents data.
- in_ready, output, 1: latch can accept; registered.
- in_data, input, NFIELDS*WIDTH: packed upstream fields.
- out_valid, output, 1: latch presents data downstream.
- out_ready, input, 1: downstream accepts.
- out_data, output, NFIELDS*WIDTH: packed fields; registered, no combinational path from in_data.
- flush, input, 1: synchronous squash (branch taken or exception).
- stall_cycles, output, CNT_W: saturating count of back-pressured cycles.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register, one entry each.
- States: EMPTY (0 entries), FULL (main holds data), SKID (main and skid both hold data).
- Output decode: out_valid = (state != EMPTY); in_ready = (state != SKID). Both decode directly from the state flops.
- EMPTY:
  - in_fire -> main <= in_data; go to FULL.
  - No in_fire -> stay in EMPTY.
- FULL:
  - in_fire & out_fire -> main <= in_data; stay in FULL.
  - in_fire & !out_fire -> skid <= in_data; go to SKID.
  - !in_fire & out_fire -> go to EMPTY; main holds its old value.
  - Neither -> hold.
- SKID:
  - out_fire -> main <= skid; go to FULL.
  - in_ready = 0, so no input is accepted in this state.
- Throughput: one word per cycle when out_ready is held at 1. Latency is 1 cycle from in_fire to out_valid on the same word.
- Data stability: out_data must not change while out_valid=1 and out_ready=0.
- Ordering: words leave in arrival order; none are dropped or duplicated except on flush.
- Flush (sampled at the clock edge, highest priority):
  - Next state is EMPTY.
  - Any in_fire in the same cycle is discarded.
  - Both entries are discarded.
  - main[IR_FIELD] <= NOP_IR; the other main fields hold.
  - One cycle after flush: out_valid=0, in_ready=1.
  - An out_fire in the flush cycle still completes normally (downstream took the word).
- Back-to-back flush: stays in EMPTY, idempotent.
- stall_cycles:
  - Increments on each clock where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset; flush does not clear it.
- Reset (reset_n=0, asynchronous, effective mid-operation and discarding all contents):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data=0 except the IR field, which is NOP_IR.
  - skid=0, stall_cycles=0.
- Reset release: synchronous deassertion is provided externally. The first transfer is possible on the first clock edge after release.
- Width rule: all fields are equal width; packing is little-endian by field index.

Test Plan:
- Reset then stream: reset_n low mid-stream with data in both entries -> out_valid=0, in_ready=1, out_data IR field=NOP_IR immediately. After release, send PC=0x10,0x14,0x18 with out_ready=1 -> out_data PC=0x10,0x14,0x18 on consecutive cycles, each 1 cycle after accept.
- Skid: FULL with PC=0x20, push PC=0x24 with out_ready=0 -> in_ready=0 next cycle and out_data stays 0x20. Raise out_ready -> 0x20 then 0x24 delivered, no loss; in_ready returns to 1 after the first out_fire.
- Flush in SKID with simultaneous in_valid (PC=0x30) -> next cycle out_valid=0, IR field=NOP_IR, the 0x30 word is never emitted, in_ready=1.
- Stall counter: hold out_ready=0 with out_valid=1 for 5 cycles -> stall_cycles=5. With CNT_W=3 and 10 stalled cycles -> stall_cycles=7.
- Simultaneous fire: FULL, in_fire & out_fire every cycle for 8 cycles -> state stays FULL, in_ready stays 1, 8 words in order.
- Parameter sweep: WIDTH=16, NFIELDS=2, IR_FIELD=1, NOP_IR=16'hFFFF -> flush yields out_data[31:16]=16'hFFFF and out_data[15:0] unchanged.

Source files
------------

// File: rtl/pipe_latch_skid.sv
// Inter-stage pipeline latch: NFIELDS x WIDTH payload, valid/ready handshake,
// two-entry skid buffer, flush-to-NOP and a saturating back-pressure counter.
module pipe_latch_skid #(
  parameter int                 WIDTH    = 32,
  parameter int                 NFIELDS  = 4,
  parameter int                 IR_FIELD = 3,
  parameter logic [WIDTH-1:0]   NOP_IR   = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NFIELDS*WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NFIELDS*WIDTH-1:0]   out_data,
  input  logic                       flush,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int DW = NFIELDS * WIDTH;
  localparam logic [DW-1:0] MAIN_RST = DW'(NOP_IR) << (IR_FIELD * WIDTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DW-1:0]     main_q;
  logic [DW-1:0]     skid_q;
  logic [DW-1:0]     main_flushed;
  logic [CNT_W-1:0]  stall_cnt;
  logic              in_fire;
  logic              out_fire;

  assign out_valid    = (state != EMPTY);
  assign in_ready     = (state != SKID);
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  assign out_data     = main_q;
  assign stall_cycles = stall_cnt;

  // A flush turns whatever sits in main into a bubble by replacing only the IR.
  always_comb begin
    main_flushed = main_q;
    main_flushed[IR_FIELD*WIDTH +: WIDTH] = NOP_IR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= MAIN_RST;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= main_flushed;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= SKID;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Scoreboard bench for pipe_latch_skid: stimulus pushes expected words, a
// negedge monitor pops and compares on every out_fire of the main instance.
module tb_pipe_latch_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, flush;
  logic [127:0] in_data, out_data;
  logic [15:0]  stall_cycles;

  logic         sm_in_valid, sm_in_ready, sm_out_valid;
  logic [127:0] sm_out_data;
  logic [2:0]   sm_stall;

  logic         sw_in_valid, sw_in_ready, sw_out_valid, sw_flush;
  logic [31:0]  sw_in_data, sw_out_data;
  logic [15:0]  sw_stall;

  pipe_latch_skid dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .stall_cycles(stall_cycles)
  );

  pipe_latch_skid #(.CNT_W(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
    .in_data(128'h1), .out_valid(sm_out_valid), .out_ready(1'b0),
    .out_data(sm_out_data), .flush(1'b0), .stall_cycles(sm_stall)
  );

  pipe_latch_skid #(.WIDTH(16), .NFIELDS(2), .IR_FIELD(1), .NOP_IR(16'hFFFF)) dut_sweep (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready),
    .in_data(sw_in_data), .out_valid(sw_out_valid), .out_ready(1'b0),
    .out_data(sw_out_data), .flush(sw_flush), .stall_cycles(sw_stall)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [127:0] tmp;

  // Field layout: {IR, B, A, PC}, each derived from PC so words are distinguishable.
  function automatic logic [127:0] mk(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc + 32'd2, pc + 32'd1, pc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("out word pc=%h", out_data[31:0]);
        chk("out_word", out_data, mon_exp);
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    sm_in_valid = 1'b0; sw_in_valid = 1'b0; sw_flush = 1'b0; sw_in_data = '0;
    repeat (2) step();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_sweep_data", sw_out_data, 32'hFFFF_0000);
    reset_n = 1'b1;

    // Fill both entries, then reset asynchronously mid-cycle.
    in_valid = 1'b1; in_data = mk(32'h100); step();
    in_data = mk(32'h104); step();
    in_valid = 1'b0;
    chk("fill_skid_in_ready", in_ready, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_stall", stall_cycles, 0);
    step();
    reset_n = 1'b1;

    // Streaming, one cycle latency.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(32'h10 + 32'(4 * i));
      exp_q.push_back(mk(32'h10 + 32'(4 * i)));
      step();
      chk("stream_latency", out_data, mk(32'h10 + 32'(4 * i)));
    end
    in_valid = 1'b0; step();
    chk("stream_drained", out_valid, 0);

    // Skid under back-pressure.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h20); exp_q.push_back(mk(32'h20)); step();
    in_data = mk(32'h24); exp_q.push_back(mk(32'h24)); step();
    in_valid = 1'b0;
    chk("skid_in_ready", in_ready, 0);
    chk("skid_hold", out_data, mk(32'h20));
    step();
    chk("skid_stable", out_data, mk(32'h20));
    out_ready = 1'b1; step();
    chk("skid_ready_back", in_ready, 1);
    chk("skid_second", out_data, mk(32'h24));
    step();
    chk("skid_drained", out_valid, 0);

    // Simultaneous in/out fire for 8 cycles.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = mk(32'h50 + 32'(4 * i));
      exp_q.push_back(mk(32'h50 + 32'(4 * i)));
      step();
      chk("simul_in_ready", in_ready, 1);
      chk("simul_data", out_data, mk(32'h50 + 32'(4 * i)));
    end
    in_valid = 1'b0; step();

    // Flush while in SKID with a word offered upstream.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h60); step();
    in_data = mk(32'h64); step();
    in_data = mk(32'h30); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    tmp = mk(32'h60); tmp[127:96] = 32'h0;
    chk("flush_skid_out_valid", out_valid, 0);
    chk("flush_skid_in_ready", in_ready, 1);
    chk("flush_skid_nop", out_data, tmp);
    out_ready = 1'b1; step();
    chk("flush_stays_empty", out_valid, 0);
    in_valid = 1'b1; in_data = mk(32'h70); exp_q.push_back(mk(32'h70)); step();
    in_valid = 1'b0; step();

    // Flush in FULL discards a concurrent in_fire; repeated flush is idempotent.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h80); step();
    in_data = mk(32'h84); flush = 1'b1; step();
    in_valid = 1'b0;
    chk("flush_full_out_valid", out_valid, 0);
    step(); step();
    flush = 1'b0;
    tmp = mk(32'h80); tmp[127:96] = 32'h0;
    chk("flush_b2b_out_valid", out_valid, 0);
    chk("flush_b2b_in_ready", in_ready, 1);
    chk("flush_b2b_data", out_data, tmp);

    // Flush coinciding with out_fire: the word is still delivered.
    in_valid = 1'b1; in_data = mk(32'h90); exp_q.push_back(mk(32'h90)); step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_fire_out_valid", out_valid, 0);

    // Stall counter from a clean reset.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("stall_cleared", stall_cycles, 0);
    in_valid = 1'b1; in_data = mk(32'h40); exp_q.push_back(mk(32'h40)); step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("stall_five", stall_cycles, 5);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Saturation with a 3-bit counter.
    sm_in_valid = 1'b1; step(); sm_in_valid = 1'b0;
    repeat (7) step();
    chk("sat_seven", sm_stall, 7);
    repeat (3) step();
    chk("sat_ten", sm_stall, 7);

    // Narrow configuration: flush replaces only the upper field.
    sw_in_valid = 1'b1; sw_in_data = 32'h5678_1234; step();
    sw_in_valid = 1'b0;
    chk("sweep_load", sw_out_data, 32'h5678_1234);
    sw_flush = 1'b1; step(); sw_flush = 1'b0;
    chk("sweep_flush", sw_out_data, 32'hFFFF_1234);
    chk("sweep_out_valid", sw_out_valid, 0);

    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
